// File: rtl/pipeline_trace_buffer_if.sv
// Host drain port of the pipeline trace buffer: FWFT entry stream with valid/ready.
// The trace buffer drives it through the master modport; the host uses the slave modport.
interface pipeline_trace_buffer_if #(
    parameter int ENTRY_W = 39
);
    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Timestamped pipeline event recorder with wrap, stop-when-full and trigger/post-capture modes.
// Define TRACE_HAZARD_CNT_EN to build the saturating per-hazard counters; otherwise cnt_* read 0.
module pipeline_trace_buffer #(
    parameter int  DEPTH   = 16,
    parameter int  TS_W    = 16,
    parameter int  CNT_W   = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int ENTRY_W = TS_W + 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_en,
    input  logic [1:0]           cfg_mode,
    input  logic [15:0]          cfg_trig_pc,
    input  logic [AW:0]          cfg_post,
    input  logic                 clear,
    input  logic                 pc_stall,
    input  logic                 if_id_stall,
    input  logic                 if_flush,
    input  logic                 id_ex_flush,
    input  logic                 load_use_hazard,
    input  logic                 br_hazard,
    input  logic                 b_hazard,
    input  logic                 retire_valid,
    input  logic [15:0]          retire_pc,
    input  logic [3:0]           retire_opcode,
    pipeline_trace_buffer_if.master rd,
    output logic [AW:0]          level,
    output logic                 overflow,
    output logic                 triggered,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     cnt_load_use,
    output logic [CNT_W-1:0]     cnt_br,
    output logic [CNT_W-1:0]     cnt_b,
    output logic [CNT_W-1:0]     cnt_flush
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        POST   = 2'b10,
        FROZEN = 2'b11
    } state_t;

    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);

    state_t              cur_state, nxt_state;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         level_q, level_nxt, post_cnt;
    logic [TS_W-1:0]     ts_q;
    logic                overflow_q, triggered_q;
    logic [2:0]          code;
    logic                has_event;
    logic                mode_stop, mode_trig, capturing, full;
    logic                do_pop, push, overwrite, trig_hit;
    logic [ENTRY_W-1:0]  entry;

    // Event priority: hazards first, then stalls, flushes, plain retire.
    always_comb begin
        code      = 3'd0;
        has_event = 1'b1;
        if (load_use_hazard)                code = 3'd1;
        else if (br_hazard)                 code = 3'd2;
        else if (b_hazard)                  code = 3'd3;
        else if (pc_stall || if_id_stall)   code = 3'd5;
        else if (if_flush || id_ex_flush)   code = 3'd4;
        else if (retire_valid)              code = 3'd0;
        else                                has_event = 1'b0;
    end

    assign entry = {ts_q, code,
                    retire_valid ? retire_pc : 16'h0000,
                    retire_valid ? retire_opcode : 4'h0};

    assign mode_stop = (cfg_mode == 2'b01);
    assign mode_trig = (cfg_mode == 2'b10);
    assign capturing = cfg_en && !clear && (cur_state == RUN || cur_state == POST);
    assign full      = (level_q == LVL_FULL);
    assign do_pop    = rd.rd_valid && rd.rd_ready;
    // A simultaneous pop frees a slot, so a full buffer only discards or overwrites without one.
    assign push      = capturing && has_event && !(mode_stop && full && !do_pop);
    assign overwrite = push && full && !do_pop;
    assign trig_hit  = push && (cur_state == RUN) && mode_trig && retire_valid &&
                       ((retire_pc == cfg_trig_pc) || (retire_opcode == 4'hF));

    always_comb begin
        level_nxt = level_q;
        if (!overwrite) begin
            if (push && !do_pop)      level_nxt = level_q + LVL_ONE;
            else if (!push && do_pop) level_nxt = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur_state <= IDLE;
        else     cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        if (clear) begin
            nxt_state = cfg_en ? RUN : IDLE;
        end else if (!cfg_en) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE: nxt_state = RUN;
                RUN: begin
                    if (trig_hit)
                        nxt_state = (cfg_post == '0) ? FROZEN : POST;
                    else if (mode_stop && push && level_nxt == LVL_FULL)
                        nxt_state = FROZEN;
                end
                POST:    if (push && post_cnt == LVL_ONE) nxt_state = FROZEN;
                default: nxt_state = FROZEN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            post_cnt    <= '0;
            ts_q        <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            post_cnt    <= '0;
            ts_q        <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            ts_q    <= ts_q + TS_W'(1);
            level_q <= level_nxt;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop || overwrite)
                rd_ptr <= rd_ptr + AW'(1);
            if (overwrite)
                overflow_q <= 1'b1;
            if (trig_hit) begin
                triggered_q <= 1'b1;
                post_cnt    <= cfg_post;
            end else if (cur_state == POST && push && post_cnt != '0) begin
                post_cnt <= post_cnt - LVL_ONE;
            end
        end
    end

    // Trace memory is deliberately not reset; only pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= entry;
    end

    assign rd.rd_valid = (level_q != '0);
    assign rd.rd_data  = mem[rd_ptr];
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign triggered   = triggered_q;
    assign state       = cur_state;

`ifdef TRACE_HAZARD_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] cnt_lu_q, cnt_br_q, cnt_b_q, cnt_fl_q;

    // Counters see every hazard while enabled, not just the one that won the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_lu_q <= '0;
            cnt_br_q <= '0;
            cnt_b_q  <= '0;
            cnt_fl_q <= '0;
        end else if (clear) begin
            cnt_lu_q <= '0;
            cnt_br_q <= '0;
            cnt_b_q  <= '0;
            cnt_fl_q <= '0;
        end else if (cfg_en) begin
            if (load_use_hazard && cnt_lu_q != CNT_MAX) cnt_lu_q <= cnt_lu_q + CNT_W'(1);
            if (br_hazard && cnt_br_q != CNT_MAX)       cnt_br_q <= cnt_br_q + CNT_W'(1);
            if (b_hazard && cnt_b_q != CNT_MAX)         cnt_b_q  <= cnt_b_q + CNT_W'(1);
            if ((if_flush || id_ex_flush) && cnt_fl_q != CNT_MAX)
                cnt_fl_q <= cnt_fl_q + CNT_W'(1);
        end
    end

    assign cnt_load_use = cnt_lu_q;
    assign cnt_br       = cnt_br_q;
    assign cnt_b        = cnt_b_q;
    assign cnt_flush    = cnt_fl_q;
`else
    assign cnt_load_use = '0;
    assign cnt_br       = '0;
    assign cnt_b        = '0;
    assign cnt_flush    = '0;
`endif

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench for pipeline_trace_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a long randomized run.
module tb_pipeline_trace_buffer;

    localparam int DEPTH   = 8;
    localparam int TS_W    = 16;
    localparam int CNT_W   = 16;
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = TS_W + 23;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_en = 1'b0;
    logic [1:0]        cfg_mode = 2'b00;
    logic [15:0]       cfg_trig_pc = 16'h0000;
    logic [AW:0]       cfg_post = '0;
    logic              clear = 1'b0;
    logic              pc_stall = 1'b0, if_id_stall = 1'b0, if_flush = 1'b0, id_ex_flush = 1'b0;
    logic              load_use_hazard = 1'b0, br_hazard = 1'b0, b_hazard = 1'b0;
    logic              retire_valid = 1'b0;
    logic [15:0]       retire_pc = 16'h0000;
    logic [3:0]        retire_opcode = 4'h0;
    logic [AW:0]       level;
    logic              overflow, triggered;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt_load_use, cnt_br, cnt_b, cnt_flush;

    int checks = 0;
    int errors = 0;

    pipeline_trace_buffer_if #(.ENTRY_W(ENTRY_W)) rif ();

    pipeline_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .cfg_trig_pc(cfg_trig_pc), .cfg_post(cfg_post), .clear(clear),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_flush(if_flush),
        .id_ex_flush(id_ex_flush), .load_use_hazard(load_use_hazard),
        .br_hazard(br_hazard), .b_hazard(b_hazard), .retire_valid(retire_valid),
        .retire_pc(retire_pc), .retire_opcode(retire_opcode), .rd(rif.slave),
        .level(level), .overflow(overflow), .triggered(triggered), .state(state),
        .cnt_load_use(cnt_load_use), .cnt_br(cnt_br), .cnt_b(cnt_b), .cnt_flush(cnt_flush)
    );

    always #5 clk = ~clk;

    // Reference model: the buffer is a plain queue, state is 0..3 as the spec numbers it.
    logic [ENTRY_W-1:0] mq[$];
    int unsigned m_ts = 0;
    int m_state = 0, m_post = 0;
    bit m_ovf = 0, m_trig = 0;
    int unsigned m_cnt_lu = 0, m_cnt_br = 0, m_cnt_b = 0, m_cnt_fl = 0;

    task automatic model_step();
        logic [2:0] c;
        bit ev, pop, wrote;
        logic [ENTRY_W-1:0] e;
        ev = 1'b1;
        if (load_use_hazard)               c = 3'd1;
        else if (br_hazard)                c = 3'd2;
        else if (b_hazard)                 c = 3'd3;
        else if (pc_stall || if_id_stall)  c = 3'd5;
        else if (if_flush || id_ex_flush)  c = 3'd4;
        else begin c = 3'd0; ev = retire_valid; end
        pop = (mq.size() != 0) && rif.rd_ready;
        if (clear) begin
            mq.delete();
            m_ts = 0; m_ovf = 0; m_trig = 0; m_post = 0;
            m_cnt_lu = 0; m_cnt_br = 0; m_cnt_b = 0; m_cnt_fl = 0;
            m_state = cfg_en ? 1 : 0;
            return;
        end
`ifdef TRACE_HAZARD_CNT_EN
        if (cfg_en) begin
            if (load_use_hazard && m_cnt_lu < 65535) m_cnt_lu++;
            if (br_hazard && m_cnt_br < 65535) m_cnt_br++;
            if (b_hazard && m_cnt_b < 65535) m_cnt_b++;
            if ((if_flush || id_ex_flush) && m_cnt_fl < 65535) m_cnt_fl++;
        end
`endif
        if (pop) void'(mq.pop_front());
        wrote = 0;
        if (cfg_en && (m_state == 1 || m_state == 2) && ev) begin
            e = {m_ts[15:0], c, retire_valid ? retire_pc : 16'h0, retire_valid ? retire_opcode : 4'h0};
            if (mq.size() < DEPTH) begin
                mq.push_back(e); wrote = 1;
            end else if (cfg_mode != 2'b01) begin
                void'(mq.pop_front()); mq.push_back(e); m_ovf = 1; wrote = 1;
            end
        end
        m_ts = (m_ts + 1) % 65536;
        if (!cfg_en) m_state = 0;
        else if (m_state == 0) m_state = 1;
        else if (m_state == 1) begin
            if (wrote && cfg_mode == 2'b10 && retire_valid &&
                (retire_pc == cfg_trig_pc || retire_opcode == 4'hF)) begin
                m_trig = 1;
                m_post = int'(cfg_post);
                m_state = (cfg_post == 0) ? 3 : 2;
            end else if (wrote && cfg_mode == 2'b01 && mq.size() == DEPTH) begin
                m_state = 3;
            end
        end else if (m_state == 2 && wrote) begin
            m_post--;
            if (m_post == 0) m_state = 3;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ts = 0; m_state = 0; m_post = 0; m_ovf = 0; m_trig = 0;
            m_cnt_lu = 0; m_cnt_br = 0; m_cnt_b = 0; m_cnt_fl = 0;
        end else begin
            model_step();
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        if (rst) return;
        checkOutput("rd_valid", 64'(rif.rd_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) checkOutput("rd_data", 64'(rif.rd_data), 64'(mq[0]));
        checkOutput("level", 64'(level), 64'(mq.size()));
        checkOutput("overflow", 64'(overflow), 64'(m_ovf));
        checkOutput("triggered", 64'(triggered), 64'(m_trig));
        checkOutput("state", 64'(state), 64'(m_state));
        checkOutput("cnt_load_use", 64'(cnt_load_use), 64'(m_cnt_lu));
        checkOutput("cnt_br", 64'(cnt_br), 64'(m_cnt_br));
        checkOutput("cnt_b", 64'(cnt_b), 64'(m_cnt_b));
        checkOutput("cnt_flush", 64'(cnt_flush), 64'(m_cnt_fl));
    endtask

    // hz = {load_use, br, b, pc_stall, if_id_stall, if_flush, id_ex_flush}; called at a negedge.
    task automatic applyStimulus(input logic rv, input logic [15:0] pc, input logic [3:0] op,
                                 input logic [6:0] hz, input logic rdy);
        retire_valid = rv; retire_pc = pc; retire_opcode = op;
        {load_use_hazard, br_hazard, b_hazard, pc_stall, if_id_stall, if_flush, id_ex_flush} = hz;
        rif.rd_ready = rdy;
        @(posedge clk);
        #1;
        compareModel();
        @(negedge clk);
    endtask

    task automatic doClear(input logic [1:0] mode, input logic [AW:0] post);
        cfg_mode = mode; cfg_post = post; clear = 1'b1;
        applyStimulus(1'b0, 16'h0, 4'h0, 7'h00, 1'b0);
        clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] ts0;
        logic [15:0] dts;
        int rdy_bias;
        rif.rd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_rd_valid", 64'(rif.rd_valid), 64'd0);
        checkOutput("reset_level", 64'(level), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);
        checkOutput("reset_triggered", 64'(triggered), 64'd0);
        checkOutput("reset_state", 64'(state), 64'd0);
        checkOutput("reset_cnt_load_use", 64'(cnt_load_use), 64'd0);
        rst = 1'b0;

        $display("[TB] wrap mode: five retires then drain");
        cfg_en = 1'b1;
        applyStimulus(1'b0, 16'h0, 4'h0, 7'h00, 1'b0);
        checkOutput("s1_state_run", 64'(state), 64'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(2 * i), 4'(i), 7'h00, 1'b0);
        checkOutput("s1_level", 64'(level), 64'd5);
        ts0 = rif.rd_data[38:23];
        for (int i = 0; i < 5; i++) begin
            dts = rif.rd_data[38:23] - ts0;
            checkOutput("s1_pc", 64'(rif.rd_data[19:4]), 64'(2 * i));
            checkOutput("s1_code", 64'(rif.rd_data[22:20]), 64'd0);
            checkOutput("s1_ts_rel", 64'(dts), 64'(i));
            applyStimulus(1'b0, 16'h0, 4'h0, 7'h00, 1'b1);
        end
        checkOutput("s1_level_empty", 64'(level), 64'd0);

        $display("[TB] wrap mode overwrite");
        doClear(2'b00, '0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'h0100 + 16'(2 * i), 4'h2, 7'h00, 1'b0);
        checkOutput("s2_level", 64'(level), 64'd8);
        checkOutput("s2_overflow", 64'(overflow), 64'd1);
        checkOutput("s2_head_pc", 64'(rif.rd_data[19:4]), 64'h0104);

        $display("[TB] stop-when-full mode");
        doClear(2'b01, '0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'h0200 + 16'(2 * i), 4'h3, 7'h00, 1'b0);
            if (i == 6) checkOutput("s3_state_before_full", 64'(state), 64'd1);
            if (i == 7) checkOutput("s3_state_frozen", 64'(state), 64'd3);
        end
        checkOutput("s3_level", 64'(level), 64'd8);
        checkOutput("s3_overflow", 64'(overflow), 64'd0);

        $display("[TB] trigger mode, post 3 then post 0");
        cfg_trig_pc = 16'h0040;
        doClear(2'b10, 4'd3);
        applyStimulus(1'b1, 16'h0010, 4'h1, 7'h00, 1'b0);
        applyStimulus(1'b1, 16'h0020, 4'h1, 7'h00, 1'b0);
        applyStimulus(1'b1, 16'h0040, 4'h1, 7'h00, 1'b0);
        checkOutput("s4_triggered", 64'(triggered), 64'd1);
        checkOutput("s4_state_post", 64'(state), 64'd2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0050 + 16'(2 * i), 4'h1, 7'h00, 1'b0);
        checkOutput("s4_state_frozen", 64'(state), 64'd3);
        checkOutput("s4_level", 64'(level), 64'd6);
        doClear(2'b10, 4'd0);
        applyStimulus(1'b1, 16'h0040, 4'h1, 7'h00, 1'b0);
        checkOutput("s4b_state_frozen", 64'(state), 64'd3);
        checkOutput("s4b_level", 64'(level), 64'd1);

        $display("[TB] simultaneous hazards");
        doClear(2'b00, '0);
        applyStimulus(1'b1, 16'h0300, 4'h5, 7'b1010010, 1'b0);
        checkOutput("s5_level", 64'(level), 64'd1);
        checkOutput("s5_code", 64'(rif.rd_data[22:20]), 64'd1);
`ifdef TRACE_HAZARD_CNT_EN
        checkOutput("s5_cnt_load_use", 64'(cnt_load_use), 64'd1);
        checkOutput("s5_cnt_br", 64'(cnt_br), 64'd0);
        checkOutput("s5_cnt_b", 64'(cnt_b), 64'd1);
        checkOutput("s5_cnt_flush", 64'(cnt_flush), 64'd1);
`else
        checkOutput("s5_cnt_load_use", 64'(cnt_load_use), 64'd0);
        checkOutput("s5_cnt_flush", 64'(cnt_flush), 64'd0);
`endif

        $display("[TB] full buffer push with pop");
        doClear(2'b00, '0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h0400 + 16'(2 * i), 4'h6, 7'h00, 1'b0);
        applyStimulus(1'b1, 16'h0500, 4'h6, 7'h00, 1'b1);
        checkOutput("s6_level", 64'(level), 64'd8);
        checkOutput("s6_overflow", 64'(overflow), 64'd0);
        checkOutput("s6_head_pc", 64'(rif.rd_data[19:4]), 64'h0402);

        $display("[TB] async reset during post-capture");
        doClear(2'b10, 4'd3);
        applyStimulus(1'b1, 16'h0040, 4'h1, 7'h00, 1'b0);
        applyStimulus(1'b1, 16'h0060, 4'h1, 7'h00, 1'b0);
        checkOutput("s7_state_post", 64'(state), 64'd2);
        rst = 1'b1;
        #1;
        checkOutput("s7_rst_state", 64'(state), 64'd0);
        checkOutput("s7_rst_level", 64'(level), 64'd0);
        checkOutput("s7_rst_triggered", 64'(triggered), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] randomized run");
        rdy_bias = 2;
        doClear(2'b00, 4'd2);
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) rdy_bias = $urandom_range(0, 4);
            if ($urandom_range(0, 63) == 0) begin
                cfg_trig_pc = $urandom_range(0, 1) ? 16'h0040 : 16'h0080;
                doClear(2'($urandom_range(0, 3)), (AW + 1)'($urandom_range(0, 8)));
            end else begin
                if (!cfg_en && $urandom_range(0, 3) == 0) cfg_en = 1'b1;
                else if (cfg_en && $urandom_range(0, 99) == 0) cfg_en = 1'b0;
                applyStimulus(1'($urandom_range(0, 1)),
                              {8'h00, 4'($urandom_range(0, 15)), 4'h0},
                              4'($urandom_range(0, 15)),
                              7'($urandom & $urandom & $urandom),
                              1'($urandom_range(0, 3) < rdy_bias));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
